// File: rtl/serial_and_collector_if.sv
// Bundle of the serial operand link and the word-level result port of the
// bit-serial AND collector.
interface serial_and_collector_if #(
  parameter int unsigned WIDTH = 2
) ();
  logic             in_valid;
  logic             in_sof;
  logic             a_bit;
  logic             b_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ab_and;
  logic             frame_err;

  modport master (
    output in_valid, in_sof, a_bit, b_bit, out_ready,
    input  in_ready, out_valid, ab_and, frame_err
  );

  modport slave (
    input  in_valid, in_sof, a_bit, b_bit, out_ready,
    output in_ready, out_valid, ab_and, frame_err
  );
endinterface

// File: rtl/serial_and_collector.sv
// Collects LSB-first serial operand bit pairs, ANDs each pair into a WIDTH-bit
// word and holds it on a valid/ready port until the consumer takes it.
module serial_and_collector #(
  parameter int unsigned WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_and_collector_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] ab_and_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             frame_err_q;

  logic             accept;
  logic [WIDTH-1:0] and_bit_d;

  assign accept    = bus.in_valid & in_ready_q;
  assign and_bit_d = WIDTH'(bus.a_bit & bus.b_bit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ab_and_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      // in_ready_q is low only in HOLD, so an accepted beat implies IDLE or SHIFT.
      if (accept) begin
        if (bus.in_sof) begin
          frame_err_q <= (state_q == SHIFT);
          ab_and_q    <= and_bit_d;
          cnt_q       <= CW'(1);
          if (WIDTH == 1) begin
            state_q     <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= SHIFT;
          end
        end else if (state_q == IDLE) begin
          frame_err_q <= 1'b1;
        end else begin
          // Upper bits were cleared by the index-0 beat, so OR-in is a plain write.
          ab_and_q <= ab_and_q | (and_bit_d << cnt_q);
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
      end else if (state_q == HOLD && bus.out_ready) begin
        state_q     <= IDLE;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ab_and    = ab_and_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_serial_and_collector.sv
// Directed bench for serial_and_collector at WIDTH=2, 1 and 8.
module tb_serial_and_collector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_and_collector_if #(.WIDTH(2)) if2 ();
  serial_and_collector_if #(.WIDTH(1)) if1 ();
  serial_and_collector_if #(.WIDTH(8)) if8 ();

  serial_and_collector #(.WIDTH(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  serial_and_collector #(.WIDTH(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  serial_and_collector #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(if8.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat2(input logic sof, input logic a, input logic b);
    if2.in_valid = 1'b1;
    if2.in_sof   = sof;
    if2.a_bit    = a;
    if2.b_bit    = b;
    step();
    if2.in_valid = 1'b0;
    if2.in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", if2.in_ready); end
    checks++; if (if2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", if2.out_valid); end
    checks++; if (if2.ab_and !== 2'b00) begin errors++; $display("FAIL reset_ab_and got=%b exp=00", if2.ab_and); end
    checks++; if (if2.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", if2.frame_err); end
    checks++; if (if1.in_ready !== 1'b1 || if8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_w1w8 got=%b%b exp=11", if1.in_ready, if8.in_ready); end
    checks++; if (if8.ab_and !== 8'h00) begin errors++; $display("FAIL reset_ab_and_w8 got=%h exp=00", if8.ab_and); end
  endtask

  task automatic test_basic();
    beat2(1'b1, 1'b1, 1'b1);
    checks++; if (if2.out_valid !== 1'b0) begin errors++; $display("FAIL basic_mid_valid got=%b exp=0", if2.out_valid); end
    checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL basic_mid_ready got=%b exp=1", if2.in_ready); end
    beat2(1'b0, 1'b1, 1'b1);
    checks++; if (if2.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", if2.out_valid); end
    checks++; if (if2.ab_and !== 2'b11) begin errors++; $display("FAIL basic_ab_and got=%b exp=11", if2.ab_and); end
    checks++; if (if2.in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got=%b exp=0", if2.in_ready); end
    step();
    checks++; if (if2.out_valid !== 1'b0) begin errors++; $display("FAIL basic_after_valid got=%b exp=0", if2.out_valid); end
    checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL basic_after_ready got=%b exp=1", if2.in_ready); end
  endtask

  task automatic test_patterns();
    beat2(1'b1, 1'b0, 1'b1);
    beat2(1'b0, 1'b1, 1'b1);
    checks++; if (if2.out_valid !== 1'b1 || if2.ab_and !== 2'b10) begin errors++; $display("FAIL pat_10 got=%b/%b exp=1/10", if2.out_valid, if2.ab_and); end
    step();
    beat2(1'b1, 1'b1, 1'b0);
    beat2(1'b0, 1'b0, 1'b1);
    checks++; if (if2.out_valid !== 1'b1 || if2.ab_and !== 2'b00) begin errors++; $display("FAIL pat_00 got=%b/%b exp=1/00", if2.out_valid, if2.ab_and); end
    step();
  endtask

  task automatic test_backpressure();
    if2.out_ready = 1'b0;
    beat2(1'b1, 1'b0, 1'b1);
    beat2(1'b0, 1'b1, 1'b1);
    if2.in_valid = 1'b1;
    if2.in_sof   = 1'b1;
    if2.a_bit    = 1'b1;
    if2.b_bit    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (if2.out_valid !== 1'b1 || if2.ab_and !== 2'b10) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%b exp=1/10", i, if2.out_valid, if2.ab_and); end
      checks++; if (if2.frame_err !== 1'b0 || if2.in_ready !== 1'b0) begin errors++; $display("FAIL bp_err_ready[%0d] got=%b/%b exp=0/0", i, if2.frame_err, if2.in_ready); end
    end
    if2.in_valid  = 1'b0;
    if2.in_sof    = 1'b0;
    if2.out_ready = 1'b1;
    step();
    checks++; if (if2.out_valid !== 1'b0 || if2.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b/%b exp=0/1", if2.out_valid, if2.in_ready); end
    checks++; if (if2.ab_and !== 2'b10) begin errors++; $display("FAIL bp_keep_ab got=%b exp=10", if2.ab_and); end
  endtask

  task automatic test_frame_err();
    beat2(1'b0, 1'b1, 1'b1);
    checks++; if (if2.frame_err !== 1'b1) begin errors++; $display("FAIL err_idle got=%b exp=1", if2.frame_err); end
    checks++; if (if2.ab_and !== 2'b10 || if2.out_valid !== 1'b0) begin errors++; $display("FAIL err_idle_ab got=%b/%b exp=10/0", if2.ab_and, if2.out_valid); end
    if2.in_valid = 1'b1;
    if2.in_sof   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (if2.frame_err !== 1'b1) begin errors++; $display("FAIL err_b2b[%0d] got=%b exp=1", i, if2.frame_err); end
    end
    if2.in_valid = 1'b0;
    step();
    checks++; if (if2.frame_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", if2.frame_err); end
    beat2(1'b1, 1'b0, 1'b0);
    checks++; if (if2.frame_err !== 1'b0 || if2.ab_and !== 2'b00) begin errors++; $display("FAIL err_sof0 got=%b/%b exp=0/00", if2.frame_err, if2.ab_and); end
    beat2(1'b1, 1'b1, 1'b1);
    checks++; if (if2.frame_err !== 1'b1 || if2.out_valid !== 1'b0) begin errors++; $display("FAIL err_restart got=%b/%b exp=1/0", if2.frame_err, if2.out_valid); end
    beat2(1'b0, 1'b0, 1'b1);
    checks++; if (if2.frame_err !== 1'b0 || if2.out_valid !== 1'b1 || if2.ab_and !== 2'b01) begin errors++; $display("FAIL err_restart_done got=%b/%b/%b exp=0/1/01", if2.frame_err, if2.out_valid, if2.ab_and); end
    step();
  endtask

  task automatic test_reset_midframe();
    beat2(1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (if2.out_valid !== 1'b0 || if2.ab_and !== 2'b00 || if2.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got=%b/%b/%b exp=0/00/1", if2.out_valid, if2.ab_and, if2.in_ready); end
    step();
    checks++; if (if2.out_valid !== 1'b0 || if2.frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet got=%b/%b exp=0/0", if2.out_valid, if2.frame_err); end
    if2.out_ready = 1'b0;
    beat2(1'b1, 1'b1, 1'b1);
    beat2(1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    if2.out_ready = 1'b1;
    checks++; if (if2.out_valid !== 1'b0 || if2.ab_and !== 2'b00 || if2.in_ready !== 1'b1) begin errors++; $display("FAIL rst_hold got=%b/%b/%b exp=0/00/1", if2.out_valid, if2.ab_and, if2.in_ready); end
    beat2(1'b1, 1'b1, 1'b1);
    beat2(1'b0, 1'b1, 1'b0);
    checks++; if (if2.out_valid !== 1'b1 || if2.ab_and !== 2'b01) begin errors++; $display("FAIL rst_next_frame got=%b/%b exp=1/01", if2.out_valid, if2.ab_and); end
    step();
  endtask

  task automatic frame8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    for (int i = 0; i < 8; i++) begin
      if8.in_valid = 1'b1;
      if8.in_sof   = (i == 0);
      if8.a_bit    = a[i];
      if8.b_bit    = b[i];
      step();
      if (i < 7) begin
        checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL w8_early_valid[%0d] got=%b exp=0", i, if8.out_valid); end
      end
    end
    if8.in_valid = 1'b0;
    if8.in_sof   = 1'b0;
    checks++; if (if8.out_valid !== 1'b1 || if8.ab_and !== exp) begin errors++; $display("FAIL w8_result got=%b/%h exp=1/%h", if8.out_valid, if8.ab_and, exp); end
    step();
    checks++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin errors++; $display("FAIL w8_release got=%b/%b exp=0/1", if8.out_valid, if8.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] w1_tab [4];
    w1_tab[0] = 3'b111;
    w1_tab[1] = 3'b100;
    w1_tab[2] = 3'b010;
    w1_tab[3] = 3'b111;
    for (int i = 0; i < 4; i++) begin
      if1.in_valid = 1'b1;
      if1.in_sof   = 1'b1;
      if1.a_bit    = w1_tab[i][2];
      if1.b_bit    = w1_tab[i][1];
      step();
      if1.in_valid = 1'b0;
      checks++; if (if1.out_valid !== 1'b1 || if1.ab_and !== w1_tab[i][0] || if1.in_ready !== 1'b0) begin errors++; $display("FAIL w1_result[%0d] got=%b/%b/%b exp=1/%b/0", i, if1.out_valid, if1.ab_and, if1.in_ready, w1_tab[i][0]); end
      step();
      checks++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1 || if1.frame_err !== 1'b0) begin errors++; $display("FAIL w1_release[%0d] got=%b/%b/%b exp=0/1/0", i, if1.out_valid, if1.in_ready, if1.frame_err); end
    end
    frame8(8'hA5, 8'h3C, 8'h24);
    frame8(8'hFF, 8'h81, 8'h81);
    frame8(8'h5A, 8'hF0, 8'h50);
  endtask

  initial begin
    if2.in_valid = 1'b0; if2.in_sof = 1'b0; if2.a_bit = 1'b0; if2.b_bit = 1'b0; if2.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_sof = 1'b0; if1.a_bit = 1'b0; if1.b_bit = 1'b0; if1.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.in_sof = 1'b0; if8.a_bit = 1'b0; if8.b_bit = 1'b0; if8.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_frame_err();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_and_collector.md
Name: serial_and_collector

Overview:
- Receiving end of a bit-serial operand link; the transmitter sends operands A and B one bit pair per beat, LSB first.
- Computes each result bit as a AND b and assembles the WIDTH-bit result AB_AND.
- Presents the result on a valid/ready output port.
- Sits between the serial operand source and the word-level logic that consumes AB_AND.

Parameters:
- WIDTH, 2, number of bit pairs per frame and width of ab_and; legal range 1 to 32.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  serial beat present.
- in_sof  input  1  start of frame; qualifies the beat carrying bit index 0.
- a_bit  input  1  operand A bit for the current index.
- b_bit  input  1  operand B bit for the current index.
- in_ready  output  1  collector accepts a beat this cycle.
- out_valid  output  1  ab_and holds a complete result.
- out_ready  input  1  consumer accepts the result.
- ab_and  output  WIDTH  assembled result; bit i = A[i] AND B[i].
- frame_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. While reset is sampled high at a clk edge:
  - state <= IDLE, bit counter <= 0, ab_and <= 0;
  - out_valid <= 0, frame_err <= 0, in_ready <= 1 after reset.
- Reset mid-frame or while in HOLD discards all partial or pending data; no output pulse follows.
- A beat is accepted when in_valid & in_ready at a clk edge.
- Beats presented while in_ready=0 are ignored and do not raise frame_err.
- in_ready is registered-state decoded: 1 in IDLE and SHIFT, 0 in HOLD.
- IDLE:
  - Accepted beat with in_sof=1: ab_and[0] <= a_bit & b_bit, count <= 1; other ab_and bits cleared to 0. Next state is HOLD if WIDTH=1, else SHIFT.
  - Accepted beat with in_sof=0: beat is dropped, frame_err pulses 1 the next cycle, state stays IDLE.
- SHIFT:
  - Accepted beat with in_sof=0: ab_and[count] <= a_bit & b_bit, count <= count+1.
  - If that beat had count = WIDTH-1, next state is HOLD.
  - Accepted beat with in_sof=1 (premature restart): frame_err pulses. The beat is treated as index 0 of a new frame: ab_and <= {0..., a_bit & b_bit}, count <= 1, and the partial frame is lost. Next state is SHIFT, or HOLD if WIDTH=1.
  - Cycles with no accepted beat hold all state; gaps of any length are legal.
- HOLD:
  - out_valid=1 and ab_and is stable until the handshake.
  - out_valid & out_ready at a clk edge: out_valid <= 0, state <= IDLE, in_ready returns to 1 the next cycle.
  - ab_and keeps its last value after the handshake until the next frame's index-0 beat.
- Latency: out_valid rises on the clk edge that accepts the final beat, i.e. visible in the cycle after that beat.
- Minimum frame period is WIDTH+1 cycles with out_ready held at 1.
- The counter is ceil(log2(WIDTH+1)) bits and never exceeds WIDTH-1 while in SHIFT.
- frame_err is registered and high for exactly one cycle per violation; back-to-back violations give back-to-back pulses.
- No combinational path exists from any input to any output.

Test Plan:
- WIDTH=2, reset then beats (sof=1,a=1,b=1), (sof=0,a=1,b=1) with out_ready=1 -> out_valid high one cycle after the 2nd beat, ab_and=2'b11, in_ready low that cycle and high the next.
- A=2'b10, B=2'b11 sent as beats (1,1),(1,1) LSB first... specifically beat0 a=0,b=1 and beat1 a=1,b=1 -> ab_and=2'b10; A=2'b01, B=2'b10 -> ab_and=2'b00.
- out_ready held 0 for 5 cycles after completion, with in_valid=1 during those cycles -> out_valid stays 1, ab_and unchanged, no beats accepted, frame_err stays 0; out_ready=1 -> IDLE next cycle.
- In IDLE, beat with sof=0 -> frame_err=1 for one cycle, ab_and unchanged. In SHIFT after 1 beat, a sof=1 beat (a=1,b=1) followed by beat (a=0,b=1) -> one frame_err pulse, then ab_and=2'b01.
- reset asserted for one cycle after the first beat of a frame -> out_valid=0, ab_and=0, in_ready=1. A following complete frame A=2'b11, B=2'b01 -> ab_and=2'b01.
- WIDTH=1 and WIDTH=8 builds, back-to-back frames with out_ready=1 and 1-cycle input gaps -> one result per frame. For WIDTH=8, A=8'hA5, B=8'h3C -> ab_and=8'h24.
